// File: rtl/alu_sched.sv
// Shares one combinational alu between two requesters with round-robin grant.
// Multi-bit shifts run as repeated 1-bit passes; the response is held until i_rsp_ready.
module alu_sched #(
  parameter int SIZE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  input  logic [3:0]      i_req_op0,
  input  logic [SIZE-1:0] i_req_a0,
  input  logic [SIZE-1:0] i_req_b0,
  input  logic [3:0]      i_req_op1,
  input  logic [SIZE-1:0] i_req_a1,
  input  logic [SIZE-1:0] i_req_b1,
  output logic [1:0]      o_req_ready,
  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [SIZE-1:0] o_rsp_data,
  input  logic            i_rsp_ready,
  output logic [3:0]      o_alu_do,
  output logic [SIZE-1:0] o_alu_a,
  output logic [SIZE-1:0] o_alu_b,
  input  logic [SIZE-1:0] i_alu_out,
  output logic            o_busy
);
  // Opcode map: MOV=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 LSR=6 LSL=7 ASR=8 ASL=9 CND=10
  localparam logic [3:0] ALU_MOV = 4'd0;
  localparam logic [3:0] ALU_LSR = 4'd6;
  localparam logic [3:0] ALU_LSL = 4'd7;
  localparam logic [3:0] ALU_ASR = 4'd8;
  localparam logic [3:0] ALU_ASL = 4'd9;
  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic            id_q, id_d, rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            grant;
  logic [3:0]      sel_op;
  logic [SIZE-1:0] sel_a, sel_b;
  logic [CW-1:0]   sel_cnt;

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {ALU_LSR, ALU_LSL, ALU_ASR, ALU_ASL};
  endfunction

  // Requester 1 wins when it is alone or when the pointer names it.
  assign grant   = i_req_valid[1] & (~i_req_valid[0] | rr_q);
  assign sel_op  = grant ? i_req_op1 : i_req_op0;
  assign sel_a   = grant ? i_req_a1  : i_req_a0;
  assign sel_b   = grant ? i_req_b1  : i_req_b0;
  assign sel_cnt = (sel_b >= SIZE) ? CW'(SIZE) : sel_b[CW-1:0];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    id_d        = id_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    o_req_ready = 2'b00;
    o_alu_do    = ALU_MOV;
    o_alu_a     = '0;
    o_alu_b     = '0;
    case (state_q)
      IDLE: begin
        if (|i_req_valid && i_rst_n) begin
          o_req_ready[grant] = 1'b1;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = grant;
          cnt_d   = sel_cnt;
          rr_d    = ~grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_shift(op_q) && cnt_q == '0) begin
          o_alu_do = ALU_MOV;
          o_alu_a  = a_q;
        end else begin
          o_alu_do = op_q;
          o_alu_a  = a_q;
          o_alu_b  = b_q;
        end
        acc_d = i_alu_out;
        if (!is_shift(op_q) || cnt_q <= CW'(1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Each pass is a 1-bit shift of the running accumulator.
        o_alu_do = op_q;
        o_alu_a  = acc_q;
        acc_d    = i_alu_out;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= ALU_MOV;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rsp_valid = (state_q == DONE);
  assign o_rsp_id    = id_q;
  assign o_rsp_data  = acc_q;
  assign o_busy      = (state_q != IDLE);

endmodule
